// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: in-order retirement, CDB completion, full flush on a committed mispredict; ROB_FORWARD_EN adds source read ports.
// Commit outputs register one edge after the head entry becomes ready; decode is held off by fullRob, and an allocation freed by a commit resumes one cycle later.
module reorder_buffer #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int INDEX = 7
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             robReq,
  input  logic [3:0]       inCommitInfo,
  input  logic [4:0]       inDestination,
  input  logic [INDEX:0]   inPHTIndex,
  input  logic [WIDTH:0]   inInstrPC,
  output logic [ROB:0]     robAllocation,
  output logic             fullRob,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbROB,
  input  logic [WIDTH:0]   cdbResult,
  input  logic             cdbMispredict,
  input  logic             cdbTaken,
  input  logic [WIDTH:0]   cdbTarget,
`ifdef ROB_FORWARD_EN
  input  logic [ROB:0]     srcTag1,
  input  logic [ROB:0]     srcTag2,
  output logic             srcReady1,
  output logic             srcReady2,
  output logic [WIDTH:0]   srcValue1,
  output logic [WIDTH:0]   srcValue2,
`endif
  output logic             validCommit,
  output logic [ROB:0]     commitROB,
  output logic [4:0]       destCommit,
  output logic [WIDTH:0]   result,
  output logic [3:0]       commitInfo,
  output logic [1:0]       controlFlow,
  output logic [WIDTH:0]   commitTarget,
  output logic [INDEX:0]   commitPHTIndex,
  output logic [WIDTH:0]   commitPC
);

  localparam int DEPTH = 2 ** (ROB + 1);
  localparam logic [ROB:0]   PTR_ONE  = (ROB + 1)'(1);
  localparam logic [ROB+1:0] CNT_ONE  = (ROB + 2)'(1);
  localparam logic [ROB+1:0] CNT_FULL = (ROB + 2)'(DEPTH);

  typedef struct packed {
    logic [3:0]     info;
    logic [4:0]     dest;
    logic [INDEX:0] pht;
    logic [WIDTH:0] pc;
  } alloc_t;

  typedef struct packed {
    logic [WIDTH:0] result;
    logic           mispredict;
    logic           taken;
    logic [WIDTH:0] target;
  } wb_t;

  alloc_t alloc_q [DEPTH];
  alloc_t alloc_d [DEPTH];
  wb_t    wb_q    [DEPTH];
  wb_t    wb_d    [DEPTH];

  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB:0]     head_q, head_d, tail_q, tail_d;
  logic [ROB+1:0]   count_q, count_d;

  logic             valid_commit_q, valid_commit_d;
  logic [ROB:0]     commit_rob_q, commit_rob_d;
  logic [4:0]       dest_commit_q, dest_commit_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [3:0]       commit_info_q, commit_info_d;
  logic [1:0]       control_flow_q, control_flow_d;
  logic [WIDTH:0]   commit_target_q, commit_target_d;
  logic [INDEX:0]   commit_pht_q, commit_pht_d;
  logic [WIDTH:0]   commit_pc_q, commit_pc_d;

  logic flush, full, do_alloc, do_wb, do_commit;

  // The flush fires the cycle the mispredicting commit is visible on the bus.
  assign flush     = valid_commit_q & control_flow_q[0];
  assign full      = (count_q == CNT_FULL);
  assign do_alloc  = robReq & ~full & ~flush;
  assign do_wb     = cdbValid & busy_q[cdbROB] & ~flush;
  assign do_commit = busy_q[head_q] & ready_q[head_q] & ~flush;

  always_comb begin
    busy_d          = busy_q;
    ready_d         = ready_q;
    alloc_d         = alloc_q;
    wb_d            = wb_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    valid_commit_d  = 1'b0;
    commit_rob_d    = commit_rob_q;
    dest_commit_d   = dest_commit_q;
    result_d        = result_q;
    commit_info_d   = commit_info_q;
    control_flow_d  = control_flow_q;
    commit_target_d = commit_target_q;
    commit_pht_d    = commit_pht_q;
    commit_pc_d     = commit_pc_q;

    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
      valid_commit_d  = 1'b1;
      commit_rob_d    = head_q;
      dest_commit_d   = alloc_q[head_q].dest;
      result_d        = wb_q[head_q].result;
      commit_info_d   = alloc_q[head_q].info;
      control_flow_d  = {wb_q[head_q].taken, wb_q[head_q].mispredict};
      commit_target_d = wb_q[head_q].target;
      commit_pht_d    = alloc_q[head_q].pht;
      commit_pc_d     = alloc_q[head_q].pc;
    end

    if (do_wb) begin
      ready_d[cdbROB] = 1'b1;
      wb_d[cdbROB]    = '{result: cdbResult, mispredict: cdbMispredict,
                          taken: cdbTaken, target: cdbTarget};
    end

    // Applied after the writeback so allocation wins on a shared entry.
    if (do_alloc) begin
      alloc_d[tail_q] = '{info: inCommitInfo, dest: inDestination,
                          pht: inPHTIndex, pc: inInstrPC};
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + PTR_ONE;
    end

    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset) begin
      busy_q          <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      valid_commit_q  <= 1'b0;
      commit_rob_q    <= '0;
      dest_commit_q   <= '0;
      result_q        <= '0;
      commit_info_q   <= '0;
      control_flow_q  <= '0;
      commit_target_q <= '0;
      commit_pht_q    <= '0;
      commit_pc_q     <= '0;
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      valid_commit_q  <= valid_commit_d;
      commit_rob_q    <= commit_rob_d;
      dest_commit_q   <= dest_commit_d;
      result_q        <= result_d;
      commit_info_q   <= commit_info_d;
      control_flow_q  <= control_flow_d;
      commit_target_q <= commit_target_d;
      commit_pht_q    <= commit_pht_d;
      commit_pc_q     <= commit_pc_d;
    end
  end

  // Payload is qualified by busy/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    alloc_q <= alloc_d;
    wb_q    <= wb_d;
  end

  assign robAllocation  = tail_q;
  assign fullRob        = full;
  assign validCommit    = valid_commit_q;
  assign commitROB      = commit_rob_q;
  assign destCommit     = dest_commit_q;
  assign result         = result_q;
  assign commitInfo     = commit_info_q;
  assign controlFlow    = control_flow_q;
  assign commitTarget   = commit_target_q;
  assign commitPHTIndex = commit_pht_q;
  assign commitPC       = commit_pc_q;

`ifdef ROB_FORWARD_EN
  assign srcReady1 = busy_q[srcTag1] & ready_q[srcTag1];
  assign srcReady2 = busy_q[srcTag2] & ready_q[srcTag2];
  assign srcValue1 = wb_q[srcTag1].result;
  assign srcValue2 = wb_q[srcTag2].result;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a queue-based program-order model checked every cycle, plus directed literal checks.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        robReq;
  logic [3:0]  inCommitInfo;
  logic [4:0]  inDestination;
  logic [7:0]  inPHTIndex;
  logic [31:0] inInstrPC;
  logic [2:0]  robAllocation;
  logic        fullRob;
  logic        cdbValid;
  logic [2:0]  cdbROB;
  logic [31:0] cdbResult;
  logic        cdbMispredict;
  logic        cdbTaken;
  logic [31:0] cdbTarget;
  logic        validCommit;
  logic [2:0]  commitROB;
  logic [4:0]  destCommit;
  logic [31:0] result;
  logic [3:0]  commitInfo;
  logic [1:0]  controlFlow;
  logic [31:0] commitTarget;
  logic [7:0]  commitPHTIndex;
  logic [31:0] commitPC;
`ifdef ROB_FORWARD_EN
  logic [2:0]  srcTag1, srcTag2;
  logic        srcReady1, srcReady2;
  logic [31:0] srcValue1, srcValue2;
`endif

  reorder_buffer dut (
    .clk(clk), .globalReset(globalReset), .robReq(robReq),
    .inCommitInfo(inCommitInfo), .inDestination(inDestination),
    .inPHTIndex(inPHTIndex), .inInstrPC(inInstrPC),
    .robAllocation(robAllocation), .fullRob(fullRob),
    .cdbValid(cdbValid), .cdbROB(cdbROB), .cdbResult(cdbResult),
    .cdbMispredict(cdbMispredict), .cdbTaken(cdbTaken), .cdbTarget(cdbTarget),
`ifdef ROB_FORWARD_EN
    .srcTag1(srcTag1), .srcTag2(srcTag2), .srcReady1(srcReady1),
    .srcReady2(srcReady2), .srcValue1(srcValue1), .srcValue2(srcValue2),
`endif
    .validCommit(validCommit), .commitROB(commitROB), .destCommit(destCommit),
    .result(result), .commitInfo(commitInfo), .controlFlow(controlFlow),
    .commitTarget(commitTarget), .commitPHTIndex(commitPHTIndex), .commitPC(commitPC)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: window is a queue of tags in program order; payload arrays indexed by tag.
  int          q_tags[$];
  int          m_tail;
  bit          m_ready[8];
  logic [31:0] m_res[8], m_tgt[8], m_pc[8];
  logic [7:0]  m_pht[8];
  logic [4:0]  m_dst[8];
  logic [3:0]  m_info[8];
  bit          m_mis[8], m_tk[8];
  bit          e_valid;
  logic [2:0]  e_rob;
  logic [4:0]  e_dst;
  logic [31:0] e_res, e_tgt, e_pc;
  logic [3:0]  e_info;
  logic [1:0]  e_cf;
  logic [7:0]  e_pht;
  bit          s_alloc, s_wb, s_com;
  int          s_tag;

  function automatic bit in_window(input int tag);
    foreach (q_tags[i]) if (q_tags[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (globalReset) begin
      q_tags.delete();
      m_tail = 0;
      e_valid = 0; e_rob = 0; e_dst = 0; e_res = 0; e_tgt = 0;
      e_pc = 0; e_info = 0; e_cf = 0; e_pht = 0;
    end else if (e_valid && e_cf[0]) begin
      q_tags.delete();
      m_tail  = 0;
      e_valid = 0;
    end else begin
      s_alloc = robReq && (q_tags.size() < 8);
      s_wb    = cdbValid && in_window(int'(cdbROB));
      s_com   = (q_tags.size() > 0) && m_ready[q_tags[0]];
      if (s_com) begin
        s_tag  = q_tags.pop_front();
        e_rob  = 3'(s_tag);
        e_dst  = m_dst[s_tag];
        e_res  = m_res[s_tag];
        e_info = m_info[s_tag];
        e_cf   = {m_tk[s_tag], m_mis[s_tag]};
        e_tgt  = m_tgt[s_tag];
        e_pht  = m_pht[s_tag];
        e_pc   = m_pc[s_tag];
      end
      if (s_wb) begin
        m_ready[cdbROB] = 1;
        m_res[cdbROB]   = cdbResult;
        m_mis[cdbROB]   = cdbMispredict;
        m_tk[cdbROB]    = cdbTaken;
        m_tgt[cdbROB]   = cdbTarget;
      end
      if (s_alloc) begin
        m_ready[m_tail] = 0;
        m_info[m_tail]  = inCommitInfo;
        m_dst[m_tail]   = inDestination;
        m_pht[m_tail]   = inPHTIndex;
        m_pc[m_tail]    = inInstrPC;
        q_tags.push_back(m_tail);
        m_tail = (m_tail + 1) % 8;
      end
      e_valid = s_com;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_robAllocation", robAllocation, m_tail);
      check("cmp_fullRob", fullRob, q_tags.size() == 8);
      check("cmp_count", dut.count_q, q_tags.size());
      check("cmp_validCommit", validCommit, e_valid);
      check("cmp_commitROB", commitROB, e_rob);
      check("cmp_destCommit", destCommit, e_dst);
      check("cmp_result", result, e_res);
      check("cmp_commitInfo", commitInfo, e_info);
      check("cmp_controlFlow", controlFlow, e_cf);
      check("cmp_commitTarget", commitTarget, e_tgt);
      check("cmp_commitPHTIndex", commitPHTIndex, e_pht);
      check("cmp_commitPC", commitPC, e_pc);
    end
  end

  int log_tags[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_log();
    tick();
    if (validCommit) log_tags.push_back(int'(commitROB));
  endtask

  task automatic idle();
    robReq = 0; inCommitInfo = 0; inDestination = 0; inPHTIndex = 0; inInstrPC = 0;
    cdbValid = 0; cdbROB = 0; cdbResult = 0; cdbMispredict = 0; cdbTaken = 0; cdbTarget = 0;
  endtask

  task automatic set_alloc(input int k);
    robReq        = 1;
    inCommitInfo  = 4'(k);
    inDestination = 5'(k + 1);
    inPHTIndex    = 8'(k * 3 + 1);
    inInstrPC     = 32'h1000 + 32'(4 * k);
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] res, input bit mis,
                         input bit tk, input logic [31:0] tgt);
    cdbValid = 1; cdbROB = 3'(tag); cdbResult = res;
    cdbMispredict = mis; cdbTaken = tk; cdbTarget = tgt;
  endtask

  task automatic do_reset();
    globalReset = 1;
    tick();
    globalReset = 0;
  endtask

  bit found;

  initial begin
    idle();
    globalReset = 1;
    tick(); tick();
    globalReset = 0;
    chk_en = 1;
    check("reset_validCommit", validCommit, 0);
    check("reset_robAllocation", robAllocation, 0);
    check("reset_fullRob", fullRob, 0);

    // Three allocations get tags 0,1,2.
    for (int i = 0; i < 3; i++) begin
      check("alloc_tag", robAllocation, i);
      set_alloc(i + 1);
      tick();
    end
    idle();
    check("alloc3_next_tag", robAllocation, 3);
    check("alloc3_count", dut.count_q, 3);
    check("alloc3_full", fullRob, 0);
    check("alloc3_valid", validCommit, 0);

    // Out-of-order completion, in-order retirement.
    set_cdb(1, 32'h55, 0, 0, 0);
    tick();
    check("no_commit_before_head_ready", validCommit, 0);
    set_cdb(0, 32'hAA, 0, 0, 0);
    tick();
    idle();
    check("commit_latency_one_edge", validCommit, 0);
    tick();
    check("commit0_valid", validCommit, 1);
    check("commit0_rob", commitROB, 0);
    check("commit0_result", result, 32'hAA);
    tick();
    check("commit1_valid", validCommit, 1);
    check("commit1_rob", commitROB, 1);
    check("commit1_result", result, 32'h55);
    tick();
    check("commit_idle", validCommit, 0);

    // Fill to 8, ignore a 9th request, wrap the tail and retire 1..7,0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(10 + i);
      tick();
    end
    check("full_asserted", fullRob, 1);
    check("full_tail_wrapped", robAllocation, 0);
    tick();
    check("ninth_req_ignored", dut.count_q, 8);
    set_cdb(0, 32'h700, 0, 0, 0);
    tick();
    cdbValid = 0;
    tick();
    check("full_commit_valid", validCommit, 1);
    check("full_commit_rob", commitROB, 0);
    check("full_released", fullRob, 0);
    check("wrap_alloc_tag", robAllocation, 0);
    set_alloc(30);
    tick();
    idle();
    check("refull", fullRob, 1);
    check("refull_tail", robAllocation, 1);
    log_tags.delete();
    for (int i = 1; i <= 8; i++) begin
      set_cdb(i % 8, 32'h800 + 32'(i), 0, 0, 0);
      tick_log();
    end
    idle();
    for (int i = 0; i < 12; i++) tick_log();
    check("wrap_commit_count", log_tags.size(), 8);
    for (int i = 0; i < 8; i++) check("wrap_commit_order", log_tags[i], (i + 1) % 8);

    // Mispredict at tag 2 flushes tags 3..5.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(20 + i);
      tick();
    end
    idle();
    set_cdb(0, 32'h200, 0, 0, 0); tick();
    set_cdb(1, 32'h201, 0, 0, 0); tick();
    set_cdb(2, 32'h222, 1, 0, 32'h100); tick();
    idle();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (validCommit && commitROB == 3'd2) found = 1;
    end
    check("mispredict_commit_seen", found, 1);
    check("mispredict_controlFlow", controlFlow, 2'b01);
    check("mispredict_target", commitTarget, 32'h100);
    set_cdb(3, 32'h333, 0, 0, 0);
    tick();
    idle();
    check("flush_count", dut.count_q, 0);
    check("flush_robAllocation", robAllocation, 0);
    check("flush_valid", validCommit, 0);
    log_tags.delete();
    set_cdb(4, 32'h444, 0, 0, 0); tick_log();
    set_cdb(5, 32'h555, 0, 0, 0); tick_log();
    set_cdb(3, 32'h333, 0, 0, 0); tick_log();
    idle();
    for (int i = 0; i < 3; i++) tick_log();
    check("stale_writes_ignored", log_tags.size(), 0);

    // Allocate and commit together at count 4.
    for (int i = 0; i < 4; i++) begin
      set_alloc(40 + i);
      tick();
    end
    idle();
    set_cdb(0, 32'h4444, 0, 1, 32'h9000);
    tick();
    idle();
    set_alloc(50);
    tick();
    idle();
    check("same_cycle_count", dut.count_q, 4);
    check("same_cycle_valid", validCommit, 1);
    check("same_cycle_result", result, 32'h4444);
    check("same_cycle_info", commitInfo, 4'h8);

    // Reset mid-stream dominates allocate and writeback.
    set_cdb(1, 32'h5555, 0, 0, 0);
    set_alloc(60);
    globalReset = 1;
    tick();
    globalReset = 0;
    idle();
    check("midrst_valid", validCommit, 0);
    check("midrst_controlFlow", controlFlow, 0);
    check("midrst_commitInfo", commitInfo, 0);
    check("midrst_commitROB", commitROB, 0);
    check("midrst_destCommit", destCommit, 0);
    check("midrst_result", result, 0);
    check("midrst_commitTarget", commitTarget, 0);
    check("midrst_commitPHTIndex", commitPHTIndex, 0);
    check("midrst_commitPC", commitPC, 0);
    check("midrst_fullRob", fullRob, 0);
    check("midrst_robAllocation", robAllocation, 0);
    tick(); tick();

`ifdef ROB_FORWARD_EN
    for (int i = 0; i < 5; i++) begin
      set_alloc(70 + i);
      tick();
    end
    idle();
    set_cdb(3, 32'h1234, 0, 0, 0);
    tick();
    idle();
    srcTag1 = 3'd3;
    srcTag2 = 3'd4;
    #1;
    check("fwd_ready1", srcReady1, 1);
    check("fwd_value1", srcValue1, 32'h1234);
    check("fwd_ready2_not_ready", srcReady2, 0);
    tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
